plic_claim_master: RTL

// - AXI4 initiator that performs the PLIC claim/complete handshake on behalf of a hardware interrupt consumer.
// - Drives the 32-bit AXI slave port of the PLIC wrapper and watches its irq output.
// - On irq, reads the context claim register and hands the source ID to the consumer; once accepted, writes the ID back as completion.

---
 rtl/plic_claim_master_if.sv | 97 +++++++++
 rtl/plic_claim_master.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/plic_claim_master_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : plic_claim_master_if
// Purpose  : AXI4 bundle between the PLIC claim master (initiator) and the
//            PLIC wrapper slave port. Single-beat, 32-bit data.
// Ports    : none; signals are grouped per channel:
//              AW : awid awaddr awlen awsize awburst awlock awcache awprot
//                   awqos awregion awvalid / awready
//              W  : wdata wstrb wlast wvalid / wready
//              B  : bid bresp bvalid / bready
//              AR : arid araddr arlen arsize arburst arlock arcache arprot
//                   arqos arregion arvalid / arready
//              R  : rid rdata rresp rlast rvalid / rready
// Modports : master (initiator side), slave (target side)
// Revision : 1.0 - initial release
// ============================================================================
interface plic_claim_master_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned ID_WIDTH   = 2
);
  // Write address channel
  logic [ID_WIDTH-1:0]   awid;
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [7:0]            awlen;
  logic [2:0]            awsize;
  logic [1:0]            awburst;
  logic                  awlock;
  logic [3:0]            awcache;
  logic [2:0]            awprot;
  logic [3:0]            awqos;
  logic [3:0]            awregion;
  logic                  awvalid;
  logic                  awready;
  // Write data channel
  logic [31:0]           wdata;
  logic [3:0]            wstrb;
  logic                  wlast;
  logic                  wvalid;
  logic                  wready;
  // Write response channel
  logic [ID_WIDTH-1:0]   bid;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;
  // Read address channel
  logic [ID_WIDTH-1:0]   arid;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [7:0]            arlen;
  logic [2:0]            arsize;
  logic [1:0]            arburst;
  logic                  arlock;
  logic [3:0]            arcache;
  logic [2:0]            arprot;
  logic [3:0]            arqos;
  logic [3:0]            arregion;
  logic                  arvalid;
  logic                  arready;
  // Read data channel
  logic [ID_WIDTH-1:0]   rid;
  logic [31:0]           rdata;
  logic [1:0]            rresp;
  logic                  rlast;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot,
           awqos, awregion, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot,
           arqos, arregion, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot,
           awqos, awregion, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot,
           arqos, arregion, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface
`default_nettype wire

// File: rtl/plic_claim_master.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : plic_claim_master
// Purpose  : AXI4 initiator performing the PLIC claim/complete handshake for
//            a hardware interrupt consumer. On irq it reads the context claim
//            register, presents the source ID to the consumer and, once the
//            consumer accepts it, writes the ID back as the completion.
// Ports    : clk_i       - clock
//            rst_i       - asynchronous reset, active-high
//            enable_i    - allow new claims (in-flight sequence always ends)
//            irq_i       - level interrupt from the PLIC
//            id_o        - claimed source ID
//            id_valid_o  - id_o valid, held until id_ready_i
//            id_ready_i  - consumer done with the ID
//            error_o     - 1-cycle pulse on non-OKAY rresp/bresp
//            m_axi       - AXI4 master port (plic_claim_master_if.master)
// Revision : 1.0 - initial release
// ============================================================================
module plic_claim_master #(
  parameter int unsigned LOCAL_ADDR_WIDTH = 32,
  parameter int unsigned LOCAL_ID_WIDTH   = 2,
  parameter logic [31:0] PLIC_BASE        = 32'h0000_0000,
  parameter int unsigned PLIC_CONTEXT     = 0,
  parameter int unsigned HOLDOFF_CYCLES   = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                enable_i,
  input  logic                irq_i,
  output logic [4:0]          id_o,
  output logic                id_valid_o,
  input  logic                id_ready_i,
  output logic                error_o,
  plic_claim_master_if.master m_axi
);

  // Claim and complete share one register per context.
  localparam logic [31:0] CLAIM_ADDR_32 =
    PLIC_BASE + 32'h0020_0004 + 32'h0000_1000 * PLIC_CONTEXT;
  localparam logic [LOCAL_ADDR_WIDTH-1:0] CLAIM_ADDR =
    LOCAL_ADDR_WIDTH'(CLAIM_ADDR_32);
  localparam logic [LOCAL_ID_WIDTH-1:0] AXI_ID = '0;

  localparam int unsigned HOLDOFF_W = $clog2(HOLDOFF_CYCLES + 1);
  localparam logic [HOLDOFF_W-1:0] HOLDOFF_LOAD = HOLDOFF_W'(HOLDOFF_CYCLES);

  localparam logic [1:0] RESP_OKAY = 2'b00;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_AR      = 3'd1;
  localparam logic [2:0] ST_R       = 3'd2;
  localparam logic [2:0] ST_PRESENT = 3'd3;
  localparam logic [2:0] ST_WR      = 3'd4;
  localparam logic [2:0] ST_B       = 3'd5;

  logic [2:0]           state;
  logic                 arvalid;
  logic                 rready;
  logic                 awvalid;
  logic                 wvalid;
  logic                 bready;
  logic [4:0]           id;
  logic                 id_valid;
  logic                 error;
  logic [HOLDOFF_W-1:0] holdoff;

  // A channel is finished once its valid is gone or it handshakes this cycle.
  logic aw_done;
  logic w_done;
  assign aw_done = !awvalid || m_axi.awready;
  assign w_done  = !wvalid  || m_axi.wready;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= ST_IDLE;
      arvalid  <= 1'b0;
      rready   <= 1'b0;
      awvalid  <= 1'b0;
      wvalid   <= 1'b0;
      bready   <= 1'b0;
      id       <= 5'd0;
      id_valid <= 1'b0;
      error    <= 1'b0;
      holdoff  <= '0;
    end else begin
      error <= 1'b0;

      // Free-running countdown; a spurious claim below reloads it.
      if (holdoff != '0) begin
        holdoff <= holdoff - 1'b1;
      end

      case (state)
        ST_IDLE: begin
          if (irq_i && enable_i && (holdoff == '0)) begin
            state   <= ST_AR;
            arvalid <= 1'b1;
          end
        end

        ST_AR: begin
          if (m_axi.arready) begin
            state   <= ST_R;
            arvalid <= 1'b0;
            rready  <= 1'b1;
          end
        end

        ST_R: begin
          if (m_axi.rvalid) begin
            rready <= 1'b0;
            if (m_axi.rresp != RESP_OKAY) begin
              error <= 1'b1;
              state <= ST_IDLE;
            end else if (m_axi.rdata == 32'd0) begin
              // Nothing pending after all: back off so a lingering irq
              // level does not hammer the claim register.
              holdoff <= HOLDOFF_LOAD;
              state   <= ST_IDLE;
            end else begin
              id       <= m_axi.rdata[4:0];
              id_valid <= 1'b1;
              state    <= ST_PRESENT;
            end
          end
        end

        ST_PRESENT: begin
          if (id_ready_i) begin
            id_valid <= 1'b0;
            awvalid  <= 1'b1;
            wvalid   <= 1'b1;
            state    <= ST_WR;
          end
        end

        ST_WR: begin
          if (aw_done && w_done) begin
            awvalid <= 1'b0;
            wvalid  <= 1'b0;
            bready  <= 1'b1;
            state   <= ST_B;
          end else begin
            // Each channel retires independently so no beat is repeated.
            if (m_axi.awready) awvalid <= 1'b0;
            if (m_axi.wready)  wvalid  <= 1'b0;
          end
        end

        ST_B: begin
          if (m_axi.bvalid) begin
            bready <= 1'b0;
            if (m_axi.bresp != RESP_OKAY) begin
              error <= 1'b1;
            end
            state <= ST_IDLE;
          end
        end

        default: begin
          state    <= ST_IDLE;
          arvalid  <= 1'b0;
          rready   <= 1'b0;
          awvalid  <= 1'b0;
          wvalid   <= 1'b0;
          bready   <= 1'b0;
          id_valid <= 1'b0;
        end
      endcase
    end
  end

  // Consumer side
  assign id_o       = id;
  assign id_valid_o = id_valid;
  assign error_o    = error;

  // Write address channel: single 32-bit INCR beat to the claim register
  assign m_axi.awid     = AXI_ID;
  assign m_axi.awaddr   = CLAIM_ADDR;
  assign m_axi.awlen    = 8'd0;
  assign m_axi.awsize   = 3'b010;
  assign m_axi.awburst  = 2'b01;
  assign m_axi.awlock   = 1'b0;
  assign m_axi.awcache  = 4'd0;
  assign m_axi.awprot   = 3'd0;
  assign m_axi.awqos    = 4'd0;
  assign m_axi.awregion = 4'd0;
  assign m_axi.awvalid  = awvalid;

  // Write data: completion carries the claimed ID
  assign m_axi.wdata  = {27'd0, id};
  assign m_axi.wstrb  = 4'hF;
  assign m_axi.wlast  = 1'b1;
  assign m_axi.wvalid = wvalid;

  assign m_axi.bready = bready;

  // Read address channel
  assign m_axi.arid     = AXI_ID;
  assign m_axi.araddr   = CLAIM_ADDR;
  assign m_axi.arlen    = 8'd0;
  assign m_axi.arsize   = 3'b010;
  assign m_axi.arburst  = 2'b01;
  assign m_axi.arlock   = 1'b0;
  assign m_axi.arcache  = 4'd0;
  assign m_axi.arprot   = 3'd0;
  assign m_axi.arqos    = 4'd0;
  assign m_axi.arregion = 4'd0;
  assign m_axi.arvalid  = arvalid;

  assign m_axi.rready = rready;

  // Only one transaction is ever outstanding, so IDs and rlast carry no
  // information for this master.
  logic unused_ok;
  assign unused_ok = &{1'b0, m_axi.rid, m_axi.bid, m_axi.rlast};

endmodule
`default_nettype wire
